// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the instruction fetch path.
package rv_fetch_pkg;

    localparam int XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [31:0] NOP = 32'h00000013;

    // Byte distance between consecutive 32-bit instructions.
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Show-ahead synchronous FIFO holding {pc, instruction} pairs for decode.
// The head entry is kept in a dedicated output register so dout is always
// registered; flush wins over push and pop.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign dout       = dout_reg;

    // Qualified operations: a pop needs data, a push needs room (or a
    // simultaneous pop), and a flush suppresses both.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer, occupancy and head-register maintenance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // The head register tracks whatever entry sits at rd_ptr after
            // the edge: the next stored entry, or the incoming word when the
            // FIFO would otherwise be empty.
            if (do_pop) begin
                if (count_reg > CNT_W'(1)) begin
                    dout_reg <= mem[rd_ptr_inc];
                end else if (do_push) begin
                    dout_reg <= din;
                end
            end else if (empty && do_push) begin
                dout_reg <= din;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the instruction memory,
// buffers fetched words with their PCs and hands them to decode.
module instr_fetch_ctrl
    import rv_fetch_pkg::*;
#(
    parameter int               XLEN      = rv_fetch_pkg::XLEN,
    parameter int               ADDR_W    = 5,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter int               BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [XLEN-1:0]   inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              misaligned_err
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   pc_next;
    logic              err_reg;
    logic              err_next;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_flush;
    logic              buf_full;
    logic              buf_empty;
    logic [2*XLEN-1:0] buf_dout;
    logic              redirect_aligned;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    // Memory is word addressed; upper PC bits simply wrap the address.
    assign imem_addr = pc_reg[ADDR_W+1:2];

    // ERROR hides whatever the buffer holds; a pop is a completed handshake.
    assign inst_valid = !buf_empty && (state_reg != ERROR);
    assign buf_pop    = inst_valid && inst_ready;

    assign inst_pc        = buf_dout[2*XLEN-1:XLEN];
    assign inst           = buf_dout[XLEN-1:0];
    assign misaligned_err = err_reg;

    // State, PC and error flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            err_reg   <= err_next;
        end
    end

    // Next-state, PC update and buffer control; redirects take priority.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        err_next   = err_reg;
        buf_push   = 1'b0;
        buf_flush  = 1'b0;
        case (state_reg)
            FETCH, HALTED: begin
                if (redirect_valid && !redirect_aligned) begin
                    // Bad target: latch the error and stop for good.
                    state_next = ERROR;
                    err_next   = 1'b1;
                    buf_flush  = 1'b1;
                end else if (redirect_valid) begin
                    buf_flush  = 1'b1;
                    pc_next    = redirect_pc;
                    state_next = halt ? HALTED : FETCH;
                end else begin
                    state_next = halt ? HALTED : FETCH;
                    if ((state_reg == FETCH) && !halt && (!buf_full || buf_pop)) begin
                        buf_push = 1'b1;
                        pc_next  = pc_reg + XLEN'(PC_INC);
                    end
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fetch_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (buf_flush),
        .push  (buf_push),
        .pop   (buf_pop),
        .din   ({pc_reg, imem_data}),
        .full  (buf_full),
        .empty (buf_empty),
        .dout  (buf_dout)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios with literal
// expectations followed by a randomized run against a queue-based model.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misaligned_err;

    logic [31:0] mem [32];
    assign imem_data = mem[imem_addr];

    instr_fetch_ctrl #(
        .XLEN      (32),
        .ADDR_W    (5),
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misaligned_err (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Reference model: PC, queue of {pc, word}, halted/error flags.
    logic [31:0] m_pc;
    logic [63:0] m_q [$];
    bit          m_halted;
    bit          m_err;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Apply one clock edge's worth of architectural behaviour to the model.
    task automatic model_step();
        bit pop;
        bit push;
        if (!rst_n) begin
            m_pc = 32'h0;
            m_q.delete();
            m_halted = 1'b0;
            m_err = 1'b0;
        end else if (m_err) begin
            // Only reset leaves the error condition.
        end else if (redirect_valid) begin
            m_q.delete();
            if (redirect_pc[1:0] != 2'b00) begin
                m_err = 1'b1;
            end else begin
                m_pc = redirect_pc;
                m_halted = halt;
            end
        end else begin
            pop  = (m_q.size() > 0) && inst_ready;
            push = !m_halted && !halt && ((m_q.size() < 2) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, mem[m_pc[6:2]]});
                m_pc = m_pc + 32'd4;
            end
            m_halted = halt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        check_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Compare process: every cycle, DUT outputs versus the model.
    initial begin
        logic exp_valid;
        forever begin
            @(negedge clk);
            if (check_en) begin
                exp_valid = (m_q.size() > 0) && !m_err;
                chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
                chk("imem_addr", {27'b0, imem_addr}, {27'b0, m_pc[6:2]});
                chk("misaligned_err", {31'b0, misaligned_err}, {31'b0, m_err});
                if (exp_valid && inst_valid) begin
                    chk("inst", inst, m_q[0][31:0]);
                    chk("inst_pc", inst_pc, m_q[0][63:32]);
                end
            end
        end
    end

    initial begin
        int r;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'h00000013;
        mem[1] = 32'h01002103;
        mem[2] = 32'h00010033;
        mem[3] = 32'h40200133;

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_addr", {27'b0, imem_addr}, 32'd0);
        chk("rst_err", {31'b0, misaligned_err}, 32'd0);

        // Stream with decode always ready.
        rst_n = 1'b1;
        tick(); chk("s0_pc", inst_pc, 32'h0);  chk("s0_inst", inst, 32'h00000013);
        tick(); chk("s1_pc", inst_pc, 32'h4);  chk("s1_inst", inst, 32'h01002103);
        tick(); chk("s2_pc", inst_pc, 32'h8);  chk("s2_inst", inst, 32'h00010033);
        tick(); chk("s3_pc", inst_pc, 32'hC);  chk("s3_inst", inst, 32'h40200133);

        // Backpressure: buffer fills with two entries, pc stops at 8.
        rst_n = 1'b0; tick(); rst_n = 1'b1; inst_ready = 1'b0;
        repeat (5) tick();
        chk("bp_addr", {27'b0, imem_addr}, 32'd2);
        chk("bp_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick(); chk("bp_rel1", inst_pc, 32'h4);
        tick(); chk("bp_rel2", inst_pc, 32'h8);

        // Redirect with a full buffer: one bubble, then the target.
        redirect_valid = 1'b1; redirect_pc = 32'h24;
        tick(); redirect_valid = 1'b0;
        chk("rd_bubble", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("rd_valid", {31'b0, inst_valid}, 32'd1);
        chk("rd_pc", inst_pc, 32'h24);
        chk("rd_inst", inst, mem[9]);

        // Halt with two entries buffered: drain, freeze, resume.
        inst_ready = 1'b0; tick();
        halt = 1'b1; inst_ready = 1'b1;
        tick(); tick(); tick();
        chk("halt_empty", {31'b0, inst_valid}, 32'd0);
        chk("halt_addr", {27'b0, imem_addr}, 32'd11);
        halt = 1'b0;
        tick(); chk("resume_gap", {31'b0, inst_valid}, 32'd0);
        tick(); chk("resume_pc", inst_pc, 32'h2C);

        // Misaligned redirect: sticky error until reset.
        redirect_valid = 1'b1; redirect_pc = 32'h1A;
        tick(); redirect_valid = 1'b0;
        chk("mis_err", {31'b0, misaligned_err}, 32'd1);
        repeat (4) tick();
        chk("mis_valid", {31'b0, inst_valid}, 32'd0);
        chk("mis_sticky", {31'b0, misaligned_err}, 32'd1);
        rst_n = 1'b0; tick();
        chk("mis_clr", {31'b0, misaligned_err}, 32'd0);
        rst_n = 1'b1; tick();
        chk("mis_restart", inst_pc, 32'h0);

        // Address wrap around the 32-word memory.
        redirect_valid = 1'b1; redirect_pc = 32'h7C;
        tick(); redirect_valid = 1'b0;
        chk("wrap_a31", {27'b0, imem_addr}, 32'd31);
        tick(); chk("wrap_p7c", inst_pc, 32'h7C); chk("wrap_a0", {27'b0, imem_addr}, 32'd0);
        tick(); chk("wrap_p80", inst_pc, 32'h80); chk("wrap_a1", {27'b0, imem_addr}, 32'd1);
        tick(); chk("wrap_p84", inst_pc, 32'h84); chk("wrap_i84", inst, mem[1]);

        // Randomized traffic checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 999);
            rst_n = (r >= 8);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            inst_ready = ($urandom_range(0, 99) < 70);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
